morse_tx: RTL and testbench
===========================

// Module: morse_tx
// PURPOSE
//  Parametrised Morse transmitter for the full A-Z alphabet, one unit-timed bit stream on DotDashOut.
//  Accepts letter codes through a Start/Ready handshake and plays each pattern MSB-first at one bit per unit.
//  Appends a fixed inter-letter gap after every pattern and signals completion with Done.
//  Sits between the switch/key front end and the LEDR/GPIO output.
// PARAMETERS
//  CLOCK_FREQUENCY  50000000            ClockIn rate in Hz
//  UNIT_CYCLES      CLOCK_FREQUENCY/2   clock cycles per Morse unit; must be >= 1
//  GAP_UNITS        3                   low units after each letter; must be >= 1
//  LETTER_W         5                   letter code width; codes 0..25 = A..Z
//  PATTERN_W        16                  shift register width; longest letter (J, Q, Y) is 13 units
// PORTS
//  ClockIn     in   1         clock, rising edge
//  Reset       in   1         synchronous, active-high
//  Start       in   1         request; a letter is accepted on an edge where Start && Ready
//  Letter      in   LETTER_W  letter code, sampled on accept
//  Ready       out  1         block can take a letter this cycle (combinational from state)
//  DotDashOut  out  1         serial Morse output; dot = 1 unit high, dash = 3 units high, 1 unit low between elements
//  NewBitOut   out  1         1-cycle pulse in the first cycle of every pattern bit, gap excluded
//  Busy        out  1         high in SEND and GAP
//  Done        out  1         1-cycle pulse in the last cycle of a letter's gap
//  Err         out  1         1-cycle pulse when Start && Ready and Letter > 25; the request is dropped
// BEHAVIOUR
//  Reset values: DotDashOut=0, NewBitOut=0, Busy=0, Done=0, Err=0, state=IDLE, pending buffer empty, Ready=1.
//  Reset asserted mid-letter aborts at once: output goes low, pending letter is discarded, no Done.
//  FSM states:
//   IDLE -> SEND on a valid accept.
//   SEND -> GAP after the last pattern bit's unit expires.
//   GAP  -> SEND when a next letter exists, otherwise GAP -> IDLE.
//  Load (accept edge k): shift reg <= left-aligned pattern, bits_left <= len, unit counter <= UNIT_CYCLES-1.
//   In cycle k+1, DotDashOut = pattern MSB and NewBitOut = 1.
//  Unit tick: fires when the counter is 0; the counter reloads to UNIT_CYCLES-1.
//   In SEND, a tick shifts left and decrements bits_left; NewBitOut pulses if bits remain.
//   A tick with bits_left==1 enters GAP with DotDashOut=0 for GAP_UNITS units.
//  Counter runs only in SEND/GAP. UNIT_CYCLES=1 gives one bit per cycle with NewBitOut high continuously.
//  Letter duration is exactly (len+GAP_UNITS)*UNIT_CYCLES cycles. Done is high in the last of those cycles.
//  Back-to-back: in Done's cycle, load the pending letter if present, else a Start accepted that cycle.
//   Either way, the next first bit follows with no extra idle cycle.
//  Ready: IDLE -> 1; SEND/GAP -> see CONFIGURATION. Start without Ready is ignored and causes no Err.
// CONFIGURATION
//  MORSE_PREFETCH_EN defined:
//   One-entry pending buffer; Ready = !pend_valid in every state.
//   Accept while Busy stores the letter; Done drains it.
//  MORSE_PREFETCH_EN undefined:
//   No buffer; Ready = (state==IDLE) || Done.
//   Start while Busy outside Done's cycle is ignored.
// STRUCTURE
//  morse_pkg:
//   State encoding (IDLE/SEND/GAP).
//   LEN_W = $clog2(PATTERN_W+1).
//   Code constants A..Z, MAX_CODE = 25.
//  Sub-module morse_lut:
//   Combinational Letter -> {valid, pattern[PATTERN_W-1:0] left-aligned, len[LEN_W-1:0]}.
//   Patterns carry no trailing zero. Example: A = 10111, len 5; E = 1, len 1.
//  Top level holds the FSM, unit counter, shift register, bits_left and the optional pending buffer.
// TESTING (UNIT_CYCLES=4, GAP_UNITS=3 unless noted)
//  Letter A, accept at edge 0 -> DotDashOut 1,0,1,1,1 each 4 cycles (cycles 1-20), then low for cycles 21-32.
//   NewBitOut at cycles 1,5,9,13,17; Done at cycle 32; Busy low from cycle 33.
//  Letter E -> single 4-cycle high then 12 low; Done 16 cycles after accept.
//  Letter 30 with Start -> Err pulse, Ready stays 1, DotDashOut stays 0, Busy stays 0.
//  PREFETCH on: A then Q while Busy -> Ready=0 after Q is stored.
//   Q's first bit appears in the cycle after A's Done; Q duration = (13+3)*4 = 64 cycles.
//  PREFETCH off: Start=B at cycle 10 of A -> ignored. Start=B held through Done's cycle -> B is accepted with no gap.
//  Reset at cycle 7 of an A send with a letter pending -> next cycle all outputs 0, Ready=1, no Done ever.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM state encoding, default widths
// and the letter code map (A=0 .. Z=25).
package morse_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam int unsigned PATTERN_W_DEF = 16;
  localparam int unsigned LEN_W         = $clog2(PATTERN_W_DEF + 1);

  localparam int unsigned CodeA = 0,  CodeB = 1,  CodeC = 2,  CodeD = 3,  CodeE = 4,  CodeF = 5;
  localparam int unsigned CodeG = 6,  CodeH = 7,  CodeI = 8,  CodeJ = 9,  CodeK = 10, CodeL = 11;
  localparam int unsigned CodeM = 12, CodeN = 13, CodeO = 14, CodeP = 15, CodeQ = 16, CodeR = 17;
  localparam int unsigned CodeS = 18, CodeT = 19, CodeU = 20, CodeV = 21, CodeW = 22, CodeX = 23;
  localparam int unsigned CodeY = 24, CodeZ = 25;
  localparam int unsigned MAX_CODE = 25;

  // Longest pattern (J, Q, Y) in units; the LUT stores raw patterns at this width.
  localparam int unsigned RAW_W = 13;

endpackage

// File: rtl/morse_lut.sv
// Letter code to Morse unit pattern: 1 per on-unit, single 0 between elements, no trailing zero.
// Pattern is left-aligned in PATTERN_W bits; valid is low for codes above MAX_CODE.
module morse_lut
  import morse_pkg::*;
#(
  parameter int unsigned LETTER_W  = 5,
  parameter int unsigned PATTERN_W = PATTERN_W_DEF,
  parameter int unsigned LEN_W_P   = LEN_W
) (
  input  logic [LETTER_W-1:0]  letter_i,
  output logic                 valid_o,
  output logic [PATTERN_W-1:0] pattern_o,
  output logic [LEN_W_P-1:0]   len_o
);

  logic [RAW_W-1:0] raw;
  int unsigned      len;

  always_comb begin
    raw = '0;
    len = 0;
    case (32'(letter_i))
      CodeA: begin raw = 13'b10111;         len = 5;  end
      CodeB: begin raw = 13'b111010101;     len = 9;  end
      CodeC: begin raw = 13'b11101011101;   len = 11; end
      CodeD: begin raw = 13'b1110101;       len = 7;  end
      CodeE: begin raw = 13'b1;             len = 1;  end
      CodeF: begin raw = 13'b101011101;     len = 9;  end
      CodeG: begin raw = 13'b111011101;     len = 9;  end
      CodeH: begin raw = 13'b1010101;       len = 7;  end
      CodeI: begin raw = 13'b101;           len = 3;  end
      CodeJ: begin raw = 13'b1011101110111; len = 13; end
      CodeK: begin raw = 13'b111010111;     len = 9;  end
      CodeL: begin raw = 13'b101110101;     len = 9;  end
      CodeM: begin raw = 13'b1110111;       len = 7;  end
      CodeN: begin raw = 13'b11101;         len = 5;  end
      CodeO: begin raw = 13'b11101110111;   len = 11; end
      CodeP: begin raw = 13'b10111011101;   len = 11; end
      CodeQ: begin raw = 13'b1110111010111; len = 13; end
      CodeR: begin raw = 13'b1011101;       len = 7;  end
      CodeS: begin raw = 13'b10101;         len = 5;  end
      CodeT: begin raw = 13'b111;           len = 3;  end
      CodeU: begin raw = 13'b1010111;       len = 7;  end
      CodeV: begin raw = 13'b101010111;     len = 9;  end
      CodeW: begin raw = 13'b101110111;     len = 9;  end
      CodeX: begin raw = 13'b11101010111;   len = 11; end
      CodeY: begin raw = 13'b1110101110111; len = 13; end
      CodeZ: begin raw = 13'b11101110101;   len = 11; end
      default: begin raw = '0;              len = 0;  end
    endcase
  end

  assign valid_o   = (32'(letter_i) <= MAX_CODE);
  assign pattern_o = PATTERN_W'(raw) << (PATTERN_W - len);
  assign len_o     = LEN_W_P'(len);

endmodule

// File: rtl/morse_tx.sv
// Unit-timed Morse transmitter: plays a letter pattern MSB-first, then GAP_UNITS low units.
// Define MORSE_PREFETCH_EN to add a one-entry pending buffer that accepts a letter while busy.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned UNIT_CYCLES     = CLOCK_FREQUENCY / 2,
  parameter int unsigned GAP_UNITS       = 3,
  parameter int unsigned LETTER_W        = 5,
  parameter int unsigned PATTERN_W       = 16
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                Start,
  input  logic [LETTER_W-1:0] Letter,
  output logic                Ready,
  output logic                DotDashOut,
  output logic                NewBitOut,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  localparam int unsigned LenW = $clog2(PATTERN_W + 1);
  localparam int unsigned CntW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned GapW = $clog2(GAP_UNITS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(UNIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PATTERN_W-1:0] sr_q, sr_d;
  logic [LenW-1:0]     bits_q, bits_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                 lut_valid;
  logic [PATTERN_W-1:0] lut_pattern;
  logic [LenW-1:0]      lut_len;

  logic tick, accept, take;

  morse_lut #(
    .LETTER_W  (LETTER_W),
    .PATTERN_W (PATTERN_W),
    .LEN_W_P   (LenW)
  ) u_lut (
    .letter_i  (Letter),
    .valid_o   (lut_valid),
    .pattern_o (lut_pattern),
    .len_o     (lut_len)
  );

  assign tick       = (cnt_q == '0);
  assign Done       = (state_q == StGap) && tick && (gap_q == GapW'(1));
  assign Busy       = (state_q != StIdle);
  assign DotDashOut = (state_q == StSend) && sr_q[PATTERN_W-1];
  assign NewBitOut  = (state_q == StSend) && (cnt_q == CntMax);
  // Reset is gated in so nothing is accepted (and no Err shows) in a reset cycle.
  assign accept     = Start && Ready && !Reset;
  assign Err        = accept && !lut_valid;
  assign take       = accept && lut_valid;

`ifdef MORSE_PREFETCH_EN
  logic                 pend_valid_q, pend_valid_d;
  logic [PATTERN_W-1:0] pend_pat_q, pend_pat_d;
  logic [LenW-1:0]      pend_len_q, pend_len_d;

  assign Ready = !pend_valid_q;
`else
  assign Ready = (state_q == StIdle) || Done;
`endif

  always_comb begin
    logic                 load;
    logic [PATTERN_W-1:0] load_pat;
    logic [LenW-1:0]      load_len;

    state_d  = state_q;
    sr_d     = sr_q;
    bits_d   = bits_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_pat = lut_pattern;
    load_len = lut_len;
`ifdef MORSE_PREFETCH_EN
    pend_valid_d = pend_valid_q;
    pend_pat_d   = pend_pat_q;
    pend_len_d   = pend_len_q;
`endif

    case (state_q)
      StIdle: begin
        load = take;
      end
      StSend: begin
        if (tick) begin
          cnt_d = CntMax;
          if (bits_q == LenW'(1)) begin
            state_d = StGap;
            gap_d   = GapW'(GAP_UNITS);
          end else begin
            sr_d   = sr_q << 1;
            bits_d = bits_q - LenW'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (tick) begin
          cnt_d = CntMax;
          gap_d = gap_q - GapW'(1);
          if (Done) begin
            state_d = StIdle;
            load    = take;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MORSE_PREFETCH_EN
    // While busy a taken letter parks in the buffer; Done drains it ahead of any new request.
    if (Done && pend_valid_q) begin
      load         = 1'b1;
      load_pat     = pend_pat_q;
      load_len     = pend_len_q;
      pend_valid_d = 1'b0;
    end else if (take && Busy && !Done) begin
      pend_valid_d = 1'b1;
      pend_pat_d   = lut_pattern;
      pend_len_d   = lut_len;
    end
`endif

    if (load) begin
      state_d = StSend;
      sr_d    = load_pat;
      bits_d  = load_len;
      cnt_d   = CntMax;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bits_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bits_q  <= bits_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MORSE_PREFETCH_EN
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      pend_valid_q <= 1'b0;
      pend_pat_q   <= '0;
      pend_len_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_pat_q   <= pend_pat_d;
      pend_len_q   <= pend_len_d;
    end
  end
`endif

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx (UNIT_CYCLES=4, GAP_UNITS=3); expected waveforms are built
// from dot/dash strings. Honours MORSE_PREFETCH_EN for the Ready/queueing expectations.
module tb_morse_tx;

  localparam int U = 4;
  localparam int G = 3;

`ifdef MORSE_PREFETCH_EN
  localparam bit Prefetch = 1'b1;
`else
  localparam bit Prefetch = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] letter;
  logic       ready, dd, nb, busy, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] code;
    string      morse;
    int         len;
  } vec_t;

  vec_t vecs[26];

  morse_tx #(
    .CLOCK_FREQUENCY (8),
    .UNIT_CYCLES     (U),
    .GAP_UNITS       (G),
    .LETTER_W        (5),
    .PATTERN_W       (16)
  ) dut (
    .ClockIn    (clk),
    .Reset      (rst),
    .Start      (start),
    .Letter     (letter),
    .Ready      (ready),
    .DotDashOut (dd),
    .NewBitOut  (nb),
    .Busy       (busy),
    .Done       (done),
    .Err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int cyc, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: {dd,nb,busy,done,ready,err} got %b expected %b",
               name, cyc, act, exp);
    end
  endtask

  // Unit u of the pattern described by a dot/dash string.
  function automatic logic bit_of(input string m, input int u);
    int pos = 0;
    int w;
    for (int k = 0; k < m.len(); k++) begin
      if (k > 0) begin
        if (u == pos) return 1'b0;
        pos++;
      end
      w = (m[k] == "-") ? 3 : 1;
      if (u >= pos && u < pos + w) return 1'b1;
      pos += w;
    end
    return 1'b0;
  endfunction

  task automatic accept(input string name, input logic [4:0] code);
    start  = 1'b1;
    letter = code;
    @(negedge clk);
    chk({name, " accept"}, 0, {dd, nb, busy, done, ready, err}, 6'b000010);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cyc);
    start = 1'b0;
    @(negedge clk);
    chk({name, " idle"}, cyc, {dd, nb, busy, done, ready, err}, 6'b000010);
    @(posedge clk); #1;
  endtask

  // Checks every cycle of a letter accepted at the previous edge, optionally driving a second
  // request on cycles [inj_at, inj_at+inj_len). Stops before cycle stop_at when nonzero.
  task automatic run_letter(input string name, input string m, input int len,
                            input int inj_at, input int inj_len, input logic [4:0] inj_code,
                            input int stop_at, output bit loaded);
    int   n = (len + G) * U;
    int   u;
    bit   pend = 1'b0;
    logic e_dd, e_nb, e_dn, e_rdy, e_err;
    loaded = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (stop_at != 0 && i == stop_at) return;
      start  = (i >= inj_at) && (i < inj_at + inj_len);
      letter = inj_code;
      @(negedge clk);
      u     = (i - 1) / U;
      e_dd  = (u < len) ? bit_of(m, u) : 1'b0;
      e_nb  = (u < len) && ((i - 1) % U == 0);
      e_dn  = (i == n);
      e_rdy = Prefetch ? !pend : e_dn;
      e_err = start && e_rdy && (inj_code > 5'd25);
      chk(name, i, {dd, nb, busy, done, ready, err}, {e_dd, e_nb, 1'b1, e_dn, e_rdy, e_err});
      if (start && e_rdy && !e_err) begin
        if (e_dn) loaded = 1'b1;
        else pend = 1'b1;
      end
      if (e_dn && pend) loaded = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit         loaded;
    logic [4:0] bad[3];

    vecs[0]  = '{5'd0,  ".-",   5};  vecs[1]  = '{5'd1,  "-...", 9};
    vecs[2]  = '{5'd2,  "-.-.", 11}; vecs[3]  = '{5'd3,  "-..",  7};
    vecs[4]  = '{5'd4,  ".",    1};  vecs[5]  = '{5'd5,  "..-.", 9};
    vecs[6]  = '{5'd6,  "--.",  9};  vecs[7]  = '{5'd7,  "....", 7};
    vecs[8]  = '{5'd8,  "..",   3};  vecs[9]  = '{5'd9,  ".---", 13};
    vecs[10] = '{5'd10, "-.-",  9};  vecs[11] = '{5'd11, ".-..", 9};
    vecs[12] = '{5'd12, "--",   7};  vecs[13] = '{5'd13, "-.",   5};
    vecs[14] = '{5'd14, "---",  11}; vecs[15] = '{5'd15, ".--.", 11};
    vecs[16] = '{5'd16, "--.-", 13}; vecs[17] = '{5'd17, ".-.",  7};
    vecs[18] = '{5'd18, "...",  5};  vecs[19] = '{5'd19, "-",    3};
    vecs[20] = '{5'd20, "..-",  7};  vecs[21] = '{5'd21, "...-", 9};
    vecs[22] = '{5'd22, ".--",  9};  vecs[23] = '{5'd23, "-..-", 11};
    vecs[24] = '{5'd24, "-.--", 13}; vecs[25] = '{5'd25, "--..", 11};
    bad[0] = 5'd26; bad[1] = 5'd30; bad[2] = 5'd31;

    rst    = 1'b1;
    start  = 1'b0;
    letter = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset", 0, {dd, nb, busy, done, ready, err}, 6'b000010);
    @(posedge clk); #1;
    rst = 1'b0;

    // Every letter, one at a time, with an idle cycle after each.
    for (int v = 0; v < 26; v++) begin
      accept(vecs[v].morse, vecs[v].code);
      run_letter(vecs[v].morse, vecs[v].morse, vecs[v].len, 0, 0, 5'd0, 0, loaded);
      check_idle(vecs[v].morse, (vecs[v].len + G) * U + 1);
    end

    // Out-of-range codes: Err pulse, request dropped.
    for (int b = 0; b < 3; b++) begin
      start  = 1'b1;
      letter = bad[b];
      @(negedge clk);
      chk("err pulse", b, {dd, nb, busy, done, ready, err}, 6'b000011);
      @(posedge clk); #1;
      check_idle("err drop", b);
    end

    // One-cycle B request mid-letter: ignored without prefetch, queued with it.
    accept("A+B", 5'd0);
    run_letter("A+B/A", ".-", 5, 10, 1, 5'd1, 0, loaded);
    if (loaded) run_letter("A+B/B", "-...", 9, 0, 0, 5'd0, 0, loaded);
    check_idle("A+B", 0);

    // Q requested early in A; with prefetch it plays straight after A's Done.
    accept("A+Q", 5'd0);
    run_letter("A+Q/A", ".-", 5, 3, 1, 5'd16, 0, loaded);
    if (loaded) run_letter("A+Q/Q", "--.-", 13, 0, 0, 5'd0, 0, loaded);
    check_idle("A+Q", 0);

    // B held from cycle 10 through A's Done: accepted either way, no idle cycle between.
    accept("A hold B", 5'd0);
    run_letter("hold/A", ".-", 5, 10, 23, 5'd1, 0, loaded);
    if (loaded) run_letter("hold/B", "-...", 9, 0, 0, 5'd0, 0, loaded);
    check_idle("hold", 0);

    // Invalid code requested while busy: Err only if Ready (prefetch), never queued.
    accept("A bad", 5'd0);
    run_letter("A bad", ".-", 5, 5, 2, 5'd30, 0, loaded);
    check_idle("A bad", 0);

    // Reset at cycle 7 of A with B pending (prefetch): abort, no Done afterwards.
    accept("rst mid", 5'd0);
    run_letter("rst mid", ".-", 5, 3, 1, 5'd1, 7, loaded);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) check_idle("after rst", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
